// File: rtl/cnn_l2_pkg.sv
// Shared layer-2 constants and the result writer state type.
package cnn_l2_pkg;
    localparam int L2_DATA_W     = 16;
    localparam int L2_ADDR_W     = 7;
    localparam int L2_OUT_COLS   = 4;
    localparam int L2_OUT_ROWS   = 11;
    localparam int L2_ROW_STRIDE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } writer_state_t;
endpackage

// File: rtl/result_fifo2.sv
// Two-entry first-word-fall-through FIFO; head is valid whenever not empty.
module result_fifo2 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] pushData,
    input  logic              pop,
    output logic [DATA_W-1:0] headData,
    output logic              full,
    output logic              empty
);
    logic [DATA_W-1:0] mem [2];
    logic              wrPtr;
    logic              rdPtr;
    logic [1:0]        count;
    logic              doPush;
    logic              doPop;

    // A push while full is only taken when the same cycle frees a slot.
    assign doPush = push && (!full || pop);
    assign doPop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wrPtr  <= 1'b0;
            rdPtr  <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= ~wrPtr;
            end
            if (doPop) begin
                rdPtr <= ~rdPtr;
            end
            count <= count + 2'(doPush) - 2'(doPop);
        end
    end

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign headData = mem[rdPtr];
endmodule

// File: rtl/result_writer_l2.sv
// Layer-2 result writer: buffers PE results and writes them row-major to the output buffer.
// Build option RESULT_WRITER_RELU_EN clamps negative results to zero on the write port.
module result_writer_l2
    import cnn_l2_pkg::*;
#(
    parameter int DATA_W     = L2_DATA_W,
    parameter int ADDR_W     = L2_ADDR_W,
    parameter int OUT_COLS   = L2_OUT_COLS,
    parameter int OUT_ROWS   = L2_OUT_ROWS,
    parameter int ROW_STRIDE = L2_ROW_STRIDE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done
);
    localparam int TOTAL = OUT_ROWS * OUT_COLS;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int COL_W = $clog2(OUT_COLS + 1);
    localparam int ROW_W = $clog2(OUT_ROWS + 1);
    localparam logic [CNT_W-1:0]  TOTAL_C  = CNT_W'(TOTAL);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(OUT_COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(OUT_ROWS - 1);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(ROW_STRIDE);

    writer_state_t     state;
    writer_state_t     stateNext;
    logic [ADDR_W-1:0] addrReg;
    logic [ADDR_W-1:0] rowStart;
    logic [COL_W-1:0]  colCnt;
    logic [ROW_W-1:0]  rowCnt;
    logic [CNT_W-1:0]  acceptCnt;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [DATA_W-1:0] fifoHead;
    logic              accept;
    logic              commit;
    logic              lastCommit;

    assign accept     = res_valid && res_ready;
    assign commit     = wr_en && wr_ready;
    assign lastCommit = commit && (rowCnt == LAST_ROW) && (colCnt == LAST_COL);

    result_fifo2 #(.DATA_W(DATA_W)) uFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (accept),
        .pushData (res_data),
        .pop      (commit),
        .headData (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = RUN;
            RUN:     if (lastCommit) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        res_ready = 1'b0;
        wr_en     = 1'b0;
        busy      = (state != IDLE);
        done      = (state == DONE);
        if (state == RUN) begin
            res_ready = !fifoFull && (acceptCnt < TOTAL_C);
            wr_en     = !fifoEmpty;
        end
    end

    // rowStart doubles as the latched base for the current frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrReg   <= '0;
            rowStart  <= '0;
            colCnt    <= '0;
            rowCnt    <= '0;
            acceptCnt <= '0;
        end else if (state == IDLE && start) begin
            addrReg   <= base;
            rowStart  <= base;
            colCnt    <= '0;
            rowCnt    <= '0;
            acceptCnt <= '0;
        end else if (state == DONE) begin
            addrReg   <= '0;
            colCnt    <= '0;
            rowCnt    <= '0;
            acceptCnt <= '0;
        end else if (state == RUN) begin
            if (accept) acceptCnt <= acceptCnt + CNT_W'(1);
            if (commit) begin
                if (colCnt == LAST_COL) begin
                    colCnt   <= '0;
                    rowCnt   <= rowCnt + ROW_W'(1);
                    rowStart <= rowStart + STRIDE_A;
                    addrReg  <= rowStart + STRIDE_A;
                end else begin
                    colCnt  <= colCnt + COL_W'(1);
                    addrReg <= addrReg + ADDR_W'(1);
                end
            end
        end
    end

    assign wr_addr = addrReg;
`ifdef RESULT_WRITER_RELU_EN
    assign wr_data = fifoHead[DATA_W-1] ? '0 : fifoHead;
`else
    assign wr_data = fifoHead;
`endif
endmodule

// File: tb/tb_result_writer_l2.sv
// Directed bench for result_writer_l2: two instances (stride 4 and stride 6) share one stimulus.
module tb_result_writer_l2;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  base;
    logic [6:0]  baseB;
    logic        res_valid;
    logic [15:0] res_data;
    logic        wr_ready;

    logic        resReadyA, wrEnA, busyA, doneA;
    logic [6:0]  wrAddrA;
    logic [15:0] wrDataA;
    logic        resReadyB, wrEnB, busyB, doneB;
    logic [6:0]  wrAddrB;
    logic [15:0] wrDataB;

    int passCnt  = 0;
    int totalCnt = 0;

    logic [6:0]  lastAddrA;
    bit          writtenB [128];
    logic [6:0]  rowStartB [11];
    logic [15:0] dataLog [3];

    always #5 clk = ~clk;

    result_writer_l2 dutA (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base),
        .res_valid(res_valid), .res_data(res_data), .res_ready(resReadyA),
        .wr_en(wrEnA), .wr_addr(wrAddrA), .wr_data(wrDataA), .wr_ready(wr_ready),
        .busy(busyA), .done(doneA)
    );

    result_writer_l2 #(.ROW_STRIDE(6)) dutB (
        .clk(clk), .rst_n(rst_n), .start(start), .base(baseB),
        .res_valid(res_valid), .res_data(res_data), .res_ready(resReadyB),
        .wr_en(wrEnB), .wr_addr(wrAddrB), .wr_data(wrDataB), .wr_ready(wr_ready),
        .busy(busyB), .done(doneB)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] inVal(input int mode, input int i);
        if (mode == 1 && i == 0) return 16'hFFFB;
        if (mode == 1 && i == 1) return 16'h0000;
        if (mode == 1 && i == 2) return 16'h0007;
        return 16'(i + 1);
    endfunction

    function automatic logic [15:0] expVal(input logic [15:0] v);
`ifdef RESULT_WRITER_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    task automatic runFrame(input logic [6:0] bA, input logic [6:0] bB, input int mode,
                            input int stallAt, input int stallLen, input int abortAt);
        int sent, commits, stallLeft, cyc, dones, occ, row, col;
        bit stalled, finished, afterDone, lastCommitPrev, commitNow, prevHold, doneExp;
        logic [6:0]  prevAddr;
        logic [15:0] prevData;
        sent = 0; commits = 0; stallLeft = 0; cyc = 0; dones = 0;
        stalled = 0; finished = 0; afterDone = 0; lastCommitPrev = 0; prevHold = 0;
        prevAddr = '0; prevData = '0;
        for (int i = 0; i < 128; i++) writtenB[i] = 0;

        @(negedge clk);
        res_valid = 1'b1; res_data = 16'hAAAA; wr_ready = 1'b1;
        #1;
        chk("idle_res_ready", resReadyA, 0);
        chk("idle_busy", busyA, 0);
        start = 1'b1; base = bA; baseB = bB; res_valid = 1'b0;
        @(negedge clk);

        while (!finished && cyc < 400) begin
            start = (cyc == 10);
            base  = 7'h00;
            if (stallAt >= 0 && commits == stallAt && !stalled) begin
                stallLeft = stallLen;
                stalled   = 1;
            end
            wr_ready  = (stallLeft == 0);
            res_valid = (sent < 44);
            res_data  = inVal(mode, sent);
            #1;
            occ     = sent - commits;
            doneExp = lastCommitPrev;
            chk("done", doneA, doneExp);
            chk("busy", busyA, !afterDone);
            if (afterDone) begin
                finished = 1;
                break;
            end
            afterDone = doneExp;
            if (doneExp) dones++;
            chk("res_ready", resReadyA, (occ < 2 && sent < 44));
            chk("wr_en", wrEnA, (occ != 0));
            if (prevHold) begin
                chk("hold_addr", wrAddrA, prevAddr);
                chk("hold_data", wrDataA, prevData);
            end
            if (stallLeft == 1) chk("stall_full_ready", resReadyA, 0);
            commitNow = wrEnA && wr_ready;
            if (commitNow) begin
                row = commits / 4;
                col = commits % 4;
                chk("addrA", wrAddrA, 7'(bA + row * 4 + col));
                chk("addrB", wrAddrB, 7'(bB + row * 6 + col));
                chk("dataA", wrDataA, expVal(inVal(mode, commits)));
                writtenB[wrAddrB] = 1;
                if (col == 0) rowStartB[row] = wrAddrB;
                if (commits < 3) dataLog[commits] = wrDataA;
                lastAddrA = wrAddrA;
            end
            prevHold       = wrEnA && !wr_ready;
            prevAddr       = wrAddrA;
            prevData       = wrDataA;
            lastCommitPrev = commitNow && (commits == 43);
            if (commitNow) commits++;
            if (resReadyA && res_valid) sent++;
            if (stallLeft > 0) stallLeft--;
            if (abortAt >= 0 && commits == abortAt) begin
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                chk("abort_res_ready", resReadyA, 0);
                chk("abort_wr_en", wrEnA, 0);
                chk("abort_wr_addr", wrAddrA, 0);
                chk("abort_wr_data", wrDataA, 0);
                chk("abort_busy", busyA, 0);
                chk("abort_done", doneA, 0);
                @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("frame_finished", finished, 1);
        chk("done_pulses", dones, 1);
        chk("commit_count", commits, 44);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base = '0; baseB = '0;
        res_valid = 1'b0; res_data = '0; wr_ready = 1'b0;
        #12;
        chk("rst_res_ready", resReadyA, 0);
        chk("rst_wr_en", wrEnA, 0);
        chk("rst_wr_addr", wrAddrA, 0);
        chk("rst_wr_data", wrDataA, 0);
        chk("rst_busy", busyA, 0);
        chk("rst_done", doneA, 0);
        @(negedge clk);
        rst_n = 1'b1;

        runFrame(7'd10, 7'd0, 0, -1, 0, -1);
        chk("last_addr_nominal", lastAddrA, 53);
        chk("strideB_row1", rowStartB[1], 6);
        chk("strideB_row10", rowStartB[10], 60);
        chk("strideB_gap4", writtenB[4], 0);
        chk("strideB_gap5", writtenB[5], 0);

        runFrame(7'd10, 7'd0, 0, 6, 5, -1);

        runFrame(7'd120, 7'd0, 0, -1, 0, -1);
        chk("wrap_last_addr", lastAddrA, 35);

        runFrame(7'd30, 7'd0, 0, -1, 0, 20);
        runFrame(7'd0, 7'd0, 0, -1, 0, -1);
        chk("restart_last_addr", lastAddrA, 43);

        runFrame(7'd0, 7'd0, 1, -1, 0, -1);
`ifdef RESULT_WRITER_RELU_EN
        chk("relu_neg", dataLog[0], 16'h0000);
`else
        chk("relu_neg", dataLog[0], 16'hFFFB);
`endif
        chk("relu_zero", dataLog[1], 16'h0000);
        chk("relu_pos", dataLog[2], 16'h0007);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule

// File: doc/result_writer_l2.md
Name: result_writer_l2

Overview:
- Write-side counterpart of the layer-2 read address generator.
- Accepts the layer-2 PE result stream over a valid/ready handshake and buffers it in a 2-entry FIFO.
- Generates row-major write addresses into the layer-2 output buffer (base + row*ROW_STRIDE + col) and drives the buffer write port, which may stall.
- Signals done once OUT_ROWS x OUT_COLS results are committed, so the controller can start the next layer.

Parameters:
DATA_W, 16, result word width
ADDR_W, 7, output-buffer address width
OUT_COLS, 4, results per output row
OUT_ROWS, 11, output rows per frame
ROW_STRIDE, 4, address increment between row starts (>= OUT_COLS)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches base, begins a frame
base  in  ADDR_W  frame base address, sampled when start is accepted
res_valid  in  1  PE result valid
res_data  in  DATA_W  PE result
res_ready  out  1  writer can accept a result
wr_en  out  1  output-buffer write strobe
wr_addr  out  ADDR_W  write address
wr_data  out  DATA_W  write data
wr_ready  in  1  buffer accepts write this cycle
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the last write commits

Behaviour:
- Reset (async, rst_n=0): state=IDLE, FIFO empty, all counters 0, base register 0.
  - Outputs at reset: res_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
- States: IDLE -> RUN on start; RUN -> DONE when the final write commits; DONE -> IDLE after exactly 1 cycle (done=1 only in DONE).
- start is ignored outside IDLE. In IDLE, res_ready=0 and results are not consumed.
- Input handshake:
  - A result is accepted when res_valid & res_ready.
  - res_ready = (state==RUN) & (FIFO not full) & (accepted count < OUT_ROWS*OUT_COLS).
  - res_ready is registered-free, combinational from state and count only; it never depends on res_valid.
- FIFO: depth 2, first-word-fall-through.
  - Simultaneous push and pop when full is legal; occupancy is unchanged.
  - Full: no push. Empty: no pop.
- Write side:
  - wr_en=1 whenever the FIFO is non-empty in RUN; wr_data = FIFO head; wr_addr = addr_reg.
  - A write commits when wr_en & wr_ready; that pops the FIFO and advances col.
  - wr_en, wr_addr and wr_data hold stable while wr_ready=0.
- Address arithmetic:
  - addr_reg = base at start; the row-start register is also loaded with base.
  - On commit with col < OUT_COLS-1: col+1, addr_reg+1.
  - On commit with col == OUT_COLS-1: col=0, row+1, row_start += ROW_STRIDE, addr_reg = new row_start.
  - All sums are modulo 2^ADDR_W; wrap-around is silent, not an error.
- Completion:
  - The final commit (row==OUT_ROWS-1, col==OUT_COLS-1) moves to DONE.
  - Counters clear on entry to IDLE.
- Latency: a result accepted at cycle t is presented with wr_en=1 at cycle t+1 at the earliest.
  - Sustained throughput is 1 write/cycle when wr_ready stays high.
- busy = (state != IDLE).
- rst_n asserted mid-frame: the frame is aborted, FIFO contents are discarded, no done pulse is produced.

Optional Feature:
- RESULT_WRITER_RELU_EN
  - Defined: wr_data = 0 when the FIFO head is negative (two's complement MSB=1); otherwise the head passes unchanged.
  - Undefined: wr_data = FIFO head, bit-exact.
  - Address, handshake and timing behaviour are identical in both builds.

Decomposition:
- Shared package cnn_l2_pkg holds:
  - L2_ADDR_W, L2_DATA_W, L2_OUT_ROWS, L2_OUT_COLS, L2_ROW_STRIDE constants.
  - State enum writer_state_t {IDLE, RUN, DONE}.
- One sub-module: result_fifo2, a parameterised DATA_W 2-entry FWFT FIFO with push/pop/full/empty.
- Address and counter logic plus the FSM stay in the top module.

Test Plan:
- Nominal frame: start with base=7'd10; 44 results 1..44 with res_valid and wr_ready held high.
  - -> Writes at addresses 10-13, 14-17, ..., 50-53, data in order.
  - -> done pulses once, 1 cycle after the 44th commit; busy then falls.
- Stride gap: ROW_STRIDE=6, base=0.
  - -> Row 1 starts at address 6, row 10 at 60; addresses 4-5 are never written.
- Backpressure: wr_ready low for 5 cycles mid-row.
  - -> FIFO fills to 2, res_ready drops.
  - -> wr_addr and wr_data stay stable, no result is lost or duplicated.
- Wrap: base=7'd120 with nominal geometry.
  - -> Addresses run 120..127, then 0, 1, ...
  - -> The final address is (120+43) mod 128 = 35.
- Reset mid-frame: assert rst_n=0 after 20 commits, then restart with base=0.
  - -> All outputs drop to 0 asynchronously.
  - -> The new frame starts at address 0, with exactly 44 writes and one done pulse.
- RESULT_WRITER_RELU_EN: inputs -5, 0, 7.
  - -> Written data is 0, 0, 7. Without the macro, the -5 word is written as 16'hFFFB.
